// File: rtl/spi_pkg.sv
// Shared constants and state type for the 24-bit SPI write link.
// Used by both the transmit and receive ends.
package spi_pkg;

  localparam int SPI_DATA_W = 24;
  localparam int SPI_CNT_W  = $clog2(SPI_DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } spi_state_e;

endpackage

// File: rtl/spi_shift_out.sv
// Parallel-load shift register; bit_o is the bit currently on the wire.
// Direction picks which end is presented and which way data moves.
module spi_shift_out #(
  parameter int W         = 24,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         bit_o
);

  logic [W-1:0] sr_q;
  logic [W-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = din;
    end else if (shift) begin
      sr_d = LSB_FIRST ? (sr_q >> 1) : (sr_q << 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign bit_o = LSB_FIRST ? sr_q[0] : sr_q[W-1];

endmodule

// File: rtl/spi_tx.sv
// SPI write-link transmitter: one word per frame under active-low spi_en.
// Define SPI_TX_PARITY_EN to append an even-parity bit to each frame.
module spi_tx
  import spi_pkg::*;
#(
  parameter int DATA_W    = SPI_DATA_W,
  parameter int IDLE_GAP  = 2,
  parameter int LSB_FIRST = 1
) (
  input  logic              spi_clk,
  input  logic              rst,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              spi_en,
  output logic              spi_sdo,
  output logic              tx_done
);

`ifdef SPI_TX_PARITY_EN
  localparam int FRAME = DATA_W + 1;
`else
  localparam int FRAME = DATA_W;
`endif

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int GAP_W = $clog2(IDLE_GAP + 2);
  localparam int GLIM  = (IDLE_GAP > 0) ? IDLE_GAP - 1 : 0;

  localparam logic [CNT_W-1:0] LAST  = CNT_W'(FRAME - 1);
  localparam logic [GAP_W-1:0] GLAST = GAP_W'(GLIM);

  spi_state_e state_q, state_d;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              en_q, en_d;
  logic              done_q, done_d;
  logic              ld, sh;
  logic [DATA_W-1:0] ld_data;
  logic              accept;

`ifdef SPI_TX_PARITY_EN
  localparam logic [CNT_W-1:0] DLAST = CNT_W'(DATA_W - 1);

  logic              par_q, par_d;
  logic [DATA_W-1:0] par_word;

  assign par_word = (LSB_FIRST != 0)
    ? {{(DATA_W-1){1'b0}}, par_q}
    : {par_q, {(DATA_W-1){1'b0}}};
`endif

  assign tx_ready = (state_q == IDLE) && !rst;
  assign accept   = tx_valid && tx_ready;

  always_ff @(posedge spi_clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = SHIFT;
      end
      SHIFT: begin
        if (cnt_q == LAST) begin
          state_d = (IDLE_GAP > 0) ? GAP : IDLE;
        end
      end
      GAP: begin
        if (gap_q == GLAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    en_d    = en_q;
    done_d  = 1'b0;
    ld      = 1'b0;
    sh      = 1'b0;
    ld_data = tx_data;
`ifdef SPI_TX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          ld    = 1'b1;
          en_d  = 1'b0;
          cnt_d = '0;
`ifdef SPI_TX_PARITY_EN
          par_d = ^tx_data;
`endif
        end
      end
      SHIFT: begin
        // Last edge of the frame: release enable, park the line low.
        if (cnt_q == LAST) begin
          ld      = 1'b1;
          ld_data = '0;
          en_d    = 1'b1;
          done_d  = 1'b1;
          gap_d   = '0;
        end
`ifdef SPI_TX_PARITY_EN
        else if (cnt_q == DLAST) begin
          ld      = 1'b1;
          ld_data = par_word;
          cnt_d   = cnt_q + CNT_W'(1);
        end
`endif
        else begin
          sh    = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        gap_d = gap_q + GAP_W'(1);
      end
      default: begin
        en_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge spi_clk) begin
    if (rst) begin
      cnt_q  <= '0;
      gap_q  <= '0;
      en_q   <= 1'b1;
      done_q <= 1'b0;
`ifdef SPI_TX_PARITY_EN
      par_q  <= 1'b0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      gap_q  <= gap_d;
      en_q   <= en_d;
      done_q <= done_d;
`ifdef SPI_TX_PARITY_EN
      par_q  <= par_d;
`endif
    end
  end

  spi_shift_out #(
    .W         (DATA_W),
    .LSB_FIRST (LSB_FIRST != 0)
  ) u_shift (
    .clk   (spi_clk),
    .rst   (rst),
    .load  (ld),
    .shift (sh),
    .din   (ld_data),
    .bit_o (spi_sdo)
  );

  assign spi_en  = en_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_spi_tx.sv
// Bench for spi_tx: LSB-first/gap-2 and MSB-first/gap-0 instances
// checked each cycle against a frame-position model, plus directed cases.
module tb_spi_tx;
  import spi_pkg::*;

  localparam int W = SPI_DATA_W;
`ifdef SPI_TX_PARITY_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         tx_valid = 1'b0;
  logic [W-1:0] tx_data = '0;

  logic rdy_a, en_a, sdo_a, done_a;
  logic rdy_b, en_b, sdo_b, done_b;

  always #5 clk = ~clk;

  spi_tx #(.DATA_W(W), .IDLE_GAP(2), .LSB_FIRST(1)) u_dut (
    .spi_clk (clk),
    .rst     (rst),
    .tx_valid(tx_valid),
    .tx_data (tx_data),
    .tx_ready(rdy_a),
    .spi_en  (en_a),
    .spi_sdo (sdo_a),
    .tx_done (done_a)
  );

  spi_tx #(.DATA_W(W), .IDLE_GAP(0), .LSB_FIRST(0)) u_msb (
    .spi_clk (clk),
    .rst     (rst),
    .tx_valid(tx_valid),
    .tx_data (tx_data),
    .tx_ready(rdy_b),
    .spi_en  (en_b),
    .spi_sdo (sdo_b),
    .tx_done (done_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each instance is idle (pos=-1) or pos cycles past its accept edge.
  int           pos[2]  = '{-1, -1};
  logic [W-1:0] word[2];
  bit           acc[2]  = '{1'b0, 1'b0};
  int           gapv[2] = '{2, 0};
  bit           lsbv[2] = '{1'b1, 1'b0};
  bit           started = 1'b0;

  function automatic bit m_ready(input int i);
    return pos[i] < 0 || pos[i] >= FRAME + gapv[i];
  endfunction

  function automatic logic bit_at(input int i, input int k);
    if (k >= W) return ^word[i];
    return lsbv[i] ? word[i][k] : word[i][W-1-k];
  endfunction

  function automatic logic [2:0] m_out(input int i);
    if (pos[i] < 0 || pos[i] > FRAME) return 3'b100;
    if (pos[i] == FRAME) return 3'b101;
    return {1'b0, bit_at(i, pos[i]), 1'b0};
  endfunction

  always @(posedge clk) begin
    if (rst) started = 1'b1;
    for (int i = 0; i < 2; i++) begin
      acc[i] = 1'b0;
      if (rst) begin
        pos[i] = -1;
      end else if (m_ready(i) && tx_valid) begin
        pos[i]  = 0;
        word[i] = tx_data;
        acc[i]  = 1'b1;
      end else if (pos[i] >= 0) begin
        if (pos[i] >= FRAME + gapv[i]) pos[i] = -1;
        else pos[i] = pos[i] + 1;
      end
    end
  end

  logic [3:0] out_v[2];
  logic [2:0] e;
  assign out_v[0] = {en_a, sdo_a, done_a, rdy_a};
  assign out_v[1] = {en_b, sdo_b, done_b, rdy_b};

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        e = m_out(i);
        chk($sformatf("u%0d_en", i), 32'(out_v[i][3]), 32'(e[2]));
        chk($sformatf("u%0d_sdo", i), 32'(out_v[i][2]), 32'(e[1]));
        chk($sformatf("u%0d_done", i), 32'(out_v[i][1]), 32'(e[0]));
        chk($sformatf("u%0d_ready", i), 32'(out_v[i][0]),
            32'(m_ready(i) && !rst));
      end
    end
  end

  // Loopback receivers: sample on negedge while spi_en is low.
  logic [31:0] rw_a = '0, rw_b = '0;
  int          rc_a = 0, rc_b = 0, hi_a = 0, last_gap_a = 0, done_cnt_a = 0;
  logic [31:0] rxw_a[$], rxw_b[$];
  int          rxl_a[$], rxl_b[$];

  always @(negedge clk) begin
    if (started) begin
      if (done_a) done_cnt_a++;
      if (!en_a) begin
        if (rc_a == 0) last_gap_a = hi_a;
        hi_a = 0;
        if (rc_a < 32) rw_a[rc_a] = sdo_a;
        rc_a++;
      end else begin
        hi_a++;
        if (rc_a > 0) begin
          rxw_a.push_back(rw_a);
          rxl_a.push_back(rc_a);
          rc_a = 0;
          rw_a = '0;
        end
      end
      if (!en_b) begin
        rw_b = {rw_b[30:0], sdo_b};
        rc_b++;
      end else if (rc_b > 0) begin
        rxw_b.push_back(rw_b);
        rxl_b.push_back(rc_b);
        rc_b = 0;
        rw_b = '0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send_a(input logic [W-1:0] d, input bit keep);
    bit ok;
    ok = 1'b0;
    tx_data  = d;
    tx_valid = 1'b1;
    for (int k = 0; k < 300; k++) begin
      tick(1);
      if (acc[0]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!keep) tx_valid = 1'b0;
    chk("accept_wait", 32'(ok), 32'd1);
  endtask

  task automatic wait_rx(input int which, input int n);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if ((which == 0 ? rxw_a.size() : rxw_b.size()) >= n) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    chk("rx_wait", 32'(ok), 32'd1);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 300; k++) begin
      if (m_ready(0) && m_ready(1)) break;
      tick(1);
    end
    tick(2);
  endtask

  task automatic clear_rx();
    rxw_a.delete();
    rxl_a.delete();
    rxw_b.delete();
    rxl_b.delete();
    done_cnt_a = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    tick(3);
    chk("rst_ready", 32'(rdy_a), 32'd0);
    chk("rst_en", 32'(en_a), 32'd1);
    chk("rst_sdo", 32'(sdo_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    rst = 1'b0;
    tick(4);
    chk("idle_ready", 32'(rdy_a), 32'd1);
    chk("idle_en", 32'(en_a), 32'd1);

    // single word, both instances take it
    clear_rx();
    send_a(24'hA5C30F, 1'b0);
    chk("first_bit_lsb", 32'(sdo_a), 32'd1);
    chk("first_bit_msb", 32'(sdo_b), 32'd1);
    chk("first_en", 32'(en_a), 32'd0);
    wait_rx(0, 1);
    wait_rx(1, 1);
    tick(2);
    if (rxw_a.size() > 0 && rxw_b.size() > 0) begin
      chk("word_lsb", 32'(rxw_a[0][W-1:0]), 32'h00A5C30F);
      chk("len_lsb", 32'(rxl_a[0]), 32'(FRAME));
      chk("word_msb", rxw_b[0] >> (FRAME - W), 32'h00A5C30F);
    end
    chk("done_once", 32'(done_cnt_a), 32'd1);
    wait_idle();

    // MSB first
    clear_rx();
    send_a(24'h800001, 1'b0);
    wait_rx(1, 1);
    if (rxw_b.size() > 0) begin
      chk("msb_word", rxw_b[0] >> (FRAME - W), 32'h00800001);
      chk("msb_first", 32'(rxw_b[0][FRAME-1]), 32'd1);
      chk("msb_len", 32'(rxl_b[0]), 32'(FRAME));
    end
    wait_idle();

    // back-to-back with valid held
    clear_rx();
    send_a(24'h000001, 1'b1);
    send_a(24'hFFFFFF, 1'b0);
    wait_rx(0, 2);
    if (rxw_a.size() > 1) begin
      chk("b2b_w0", 32'(rxw_a[0][W-1:0]), 32'h00000001);
      chk("b2b_w1", 32'(rxw_a[1][W-1:0]), 32'h00FFFFFF);
      chk("b2b_len", 32'(rxl_a[1]), 32'(FRAME));
    end
    chk("b2b_gap", 32'(last_gap_a), 32'd3);
    wait_idle();

    // reset mid-frame
    clear_rx();
    send_a(24'h123456, 1'b0);
    tick(10);
    rst = 1'b1;
    tick(1);
    chk("abort_en", 32'(en_a), 32'd1);
    chk("abort_sdo", 32'(sdo_a), 32'd0);
    chk("abort_done", 32'(done_a), 32'd0);
    rst = 1'b0;
    tick(3);
    chk("abort_no_done", 32'(done_cnt_a), 32'd0);
    clear_rx();
    send_a(24'h00ABCD, 1'b0);
    wait_rx(0, 1);
    if (rxw_a.size() > 0) begin
      chk("after_abort", 32'(rxw_a[0][W-1:0]), 32'h0000ABCD);
      chk("after_len", 32'(rxl_a[0]), 32'(FRAME));
    end
    wait_idle();

`ifdef SPI_TX_PARITY_EN
    clear_rx();
    send_a(24'h000007, 1'b0);
    wait_rx(0, 1);
    if (rxw_a.size() > 0) begin
      chk("par7_bit", 32'(rxw_a[0][W]), 32'd1);
      chk("par7_len", 32'(rxl_a[0]), 32'd25);
    end
    wait_idle();
    clear_rx();
    send_a(24'h000003, 1'b0);
    wait_rx(0, 1);
    if (rxw_a.size() > 0) begin
      chk("par3_bit", 32'(rxw_a[0][W]), 32'd0);
    end
    wait_idle();
`endif

    // random traffic with occasional resets
    for (int k = 0; k < 1500; k++) begin
      rst      = ($urandom_range(0, 149) == 0);
      tx_valid = ($urandom_range(0, 2) != 0);
      tx_data  = W'($urandom);
      tick(1);
    end
    rst      = 1'b0;
    tx_valid = 1'b0;
    tick(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
